// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game controller: state codes and output-vector layout.
package genius_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_INIT   = 4'd0,
    S_SETUP  = 4'd1,
    S_PREP   = 4'd2,
    S_FPGA   = 4'd3,
    S_USER   = 4'd4,
    S_CHECK  = 4'd5,
    S_NEXT   = 4'd6,
    S_WINCHK = 4'd7,
    S_RESULT = 4'd8
  } state_e;

  // Bit positions inside the decoded control vector
  localparam int unsigned OUT_R1  = 0;
  localparam int unsigned OUT_R2  = 1;
  localparam int unsigned OUT_E1  = 2;
  localparam int unsigned OUT_E2  = 3;
  localparam int unsigned OUT_E3  = 4;
  localparam int unsigned OUT_E4  = 5;
  localparam int unsigned OUT_SEL = 6;
  localparam int unsigned OUT_W   = 7;

endpackage

// File: rtl/genius_controller_rise_detect.sv
// Rising-edge detector for a synchronized level input (one flop plus AND).
module rise_detect (
  input  logic clock,
  input  logic R_i,
  input  logic d_i,
  output logic rise_o
);

  logic r_d_q;

  always_ff @(posedge clock) begin
    if (R_i) r_d_q <= 1'b0;
    else     r_d_q <= d_i;
  end

  assign rise_o = d_i & ~r_d_q;

endmodule

// File: rtl/genius_controller.sv
// Moore FSM sequencing the Genius Datapath (setup, display, entry, compare, result).
// Optional result hold timeout enabled with macro GENIUS_RESULT_HOLD_EN.
module genius_controller
  import genius_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned HOLD_W      = 26
) (
  input  logic               clock,
  input  logic               R_i,
  input  logic               enter_i,
  input  logic               end_FPGA_i,
  input  logic               end_User_i,
  input  logic               end_time_i,
  input  logic               win_i,
  input  logic               match_i,
  output logic               R1_o,
  output logic               R2_o,
  output logic               E1_o,
  output logic               E2_o,
  output logic               E3_o,
  output logic               E4_o,
  output logic               SEL_o,
  output logic [STATE_W-1:0] state_o
);

  if ((64'd1 << HOLD_W) <= 64'(HOLD_CYCLES)) begin : g_bad_hold_cfg
    $error("HOLD_W too narrow for HOLD_CYCLES");
  end

  state_e             r_state;
  state_e             w_state_d;
  logic               w_enter_rise;
  logic               w_hold_done;
  logic [OUT_W-1:0]   w_out;

  rise_detect u_enter_rise (
    .clock  (clock),
    .R_i    (R_i),
    .d_i    (enter_i),
    .rise_o (w_enter_rise)
  );

`ifdef GENIUS_RESULT_HOLD_EN
  logic [HOLD_W-1:0] r_hold_cnt;

  // Counts cycles spent in S_RESULT; zero on the first cycle there
  always_ff @(posedge clock) begin
    if (R_i || (r_state != S_RESULT)) r_hold_cnt <= '0;
    else                              r_hold_cnt <= r_hold_cnt + 1'b1;
  end

  assign w_hold_done = (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
`else
  assign w_hold_done = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (R_i) r_state <= S_INIT;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_INIT:   w_state_d = S_SETUP;
      S_SETUP:  if (w_enter_rise) w_state_d = S_PREP;
      S_PREP:   w_state_d = S_FPGA;
      S_FPGA:   if (end_FPGA_i) w_state_d = S_USER;
      // Completed entry takes priority over a coincident timeout
      S_USER: begin
        if (end_User_i)      w_state_d = S_CHECK;
        else if (end_time_i) w_state_d = S_RESULT;
      end
      S_CHECK:  w_state_d = match_i ? S_NEXT : S_RESULT;
      S_NEXT:   w_state_d = S_WINCHK;
      S_WINCHK: w_state_d = win_i ? S_RESULT : S_PREP;
      S_RESULT: if (w_enter_rise || w_hold_done) w_state_d = S_INIT;
      default:  w_state_d = S_INIT;
    endcase
  end

  always_comb begin
    w_out = '0;
    case (r_state)
      S_INIT:   begin
        w_out[OUT_R1] = 1'b1;
        w_out[OUT_R2] = 1'b1;
      end
      S_SETUP:  w_out[OUT_E1]  = 1'b1;
      S_PREP:   w_out[OUT_R2]  = 1'b1;
      S_FPGA:   w_out[OUT_E3]  = 1'b1;
      S_USER:   w_out[OUT_E2]  = 1'b1;
      S_CHECK:  w_out          = '0;
      S_NEXT:   w_out[OUT_E4]  = 1'b1;
      S_WINCHK: w_out          = '0;
      S_RESULT: w_out[OUT_SEL] = 1'b1;
      default: begin
        w_out[OUT_R1] = 1'b1;
        w_out[OUT_R2] = 1'b1;
      end
    endcase
  end

  assign R1_o    = w_out[OUT_R1];
  assign R2_o    = w_out[OUT_R2];
  assign E1_o    = w_out[OUT_E1];
  assign E2_o    = w_out[OUT_E2];
  assign E3_o    = w_out[OUT_E3];
  assign E4_o    = w_out[OUT_E4];
  assign SEL_o   = w_out[OUT_SEL];
  assign state_o = r_state;

endmodule

// File: tb/tb_genius_controller.sv
// Self-checking bench for genius_controller: directed game scenarios plus random play
// against a phase-level game model.
module tb_genius_controller;

  localparam int Hold = 16;

  logic       clock;
  logic       R_i, enter_i, end_FPGA_i, end_User_i, end_time_i, win_i, match_i;
  logic       R1_o, R2_o, E1_o, E2_o, E3_o, E4_o, SEL_o;
  logic [3:0] state_o;

  genius_controller #(
    .HOLD_CYCLES (Hold),
    .HOLD_W      (5)
  ) dut (
    .clock      (clock),
    .R_i        (R_i),
    .enter_i    (enter_i),
    .end_FPGA_i (end_FPGA_i),
    .end_User_i (end_User_i),
    .end_time_i (end_time_i),
    .win_i      (win_i),
    .match_i    (match_i),
    .R1_o       (R1_o),
    .R2_o       (R2_o),
    .E1_o       (E1_o),
    .E2_o       (E2_o),
    .E3_o       (E3_o),
    .E4_o       (E4_o),
    .SEL_o      (SEL_o),
    .state_o    (state_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  // Game model: current phase, previous ENTER level, cycles spent showing the result
  int m_phase  = 0;
  bit m_prev   = 1'b0;
  int m_shown  = 0;
  int m_rounds_won = 0;
  int dut_e4_pulses = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Control lines the Datapath should see in each game phase, as {SEL,E4,E3,E2,E1,R2,R1}
  function automatic int phase_controls(input int ph);
    int v;
    v = 0;
    if (ph == 0)           v = 'b0000011;
    else if (ph == 1)      v = 'b0000100;
    else if (ph == 2)      v = 'b0000010;
    else if (ph == 3)      v = 'b0010000;
    else if (ph == 4)      v = 'b0001000;
    else if (ph == 6)      v = 'b0100000;
    else if (ph == 8)      v = 'b1000000;
    return v;
  endfunction

  task automatic model_edge();
    bit pressed;
    int nxt;
    if (R_i) begin
      m_phase = 0;
      m_prev  = 1'b0;
      return;
    end
    pressed = enter_i && !m_prev;
    m_prev  = enter_i;
    nxt     = m_phase;
    if (m_phase == 0) nxt = 1;
    else if (m_phase == 1 && pressed) nxt = 2;
    else if (m_phase == 2) nxt = 3;
    else if (m_phase == 3 && end_FPGA_i) nxt = 4;
    else if (m_phase == 4) nxt = end_User_i ? 5 : (end_time_i ? 8 : 4);
    else if (m_phase == 5) nxt = match_i ? 6 : 8;
    else if (m_phase == 6) nxt = 7;
    else if (m_phase == 7) nxt = win_i ? 8 : 2;
    else if (m_phase == 8) begin
`ifdef GENIUS_RESULT_HOLD_EN
      if (pressed || m_shown == Hold - 1) nxt = 0;
`else
      if (pressed) nxt = 0;
`endif
    end
    if (nxt == 8 && m_phase != 8) m_shown = 0;
    else if (m_phase == 8)        m_shown++;
    if (nxt == 6) m_rounds_won++;
    m_phase = nxt;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("controls", int'({SEL_o, E4_o, E3_o, E2_o, E1_o, R2_o, R1_o}), phase_controls(m_phase));
    check("state", int'(state_o), m_phase);
    if (E4_o) dut_e4_pulses++;
  endtask

  task automatic clear_flags();
    end_FPGA_i = 0; end_User_i = 0; end_time_i = 0; win_i = 0; match_i = 0;
  endtask

  // Drive the game from any phase into user entry, with a cycle budget
  task automatic goto_user();
    int n;
    n = 0;
    while (m_phase != 4 && n < 40) begin
      clear_flags();
      if (m_phase == 1 || m_phase == 8) enter_i = ~enter_i;
      else enter_i = 0;
      if (m_phase == 3) end_FPGA_i = 1;
      if (m_phase == 5) match_i = 1;
      step();
      n++;
    end
    clear_flags();
    enter_i = 0;
    check("goto_user_reached", m_phase, 4);
  endtask

  initial begin
    R_i = 1; enter_i = 0;
    clear_flags();

    // T1 reset
    step(); step();
    check("t1_state_reset", int'(state_o), 0);
    check("t1_r1r2", int'({R1_o, R2_o}), 3);
    R_i = 0;
    step();
    check("t1_state_setup", int'(state_o), 1);
    check("t1_e1", int'(E1_o), 1);

    // T2 one won round
    enter_i = 1; step();
    check("t2_prep", int'(state_o), 2);
    enter_i = 0; step();
    check("t2_fpga_e3", int'({state_o, E3_o}), 7);
    end_FPGA_i = 1; step();
    check("t2_user", int'(state_o), 4);
    end_FPGA_i = 0; end_User_i = 1; match_i = 1; step();
    check("t2_check", int'(state_o), 5);
    step();
    check("t2_next_e4", int'({state_o, E4_o}), 13);
    step();
    check("t2_winchk_e4_low", int'({state_o, E4_o}), 14);
    clear_flags(); step();
    check("t2_back_prep", int'(state_o), 2);

    // T3 loss by mismatch
    goto_user();
    end_User_i = 1; match_i = 0; step();
    check("t3_check", int'(state_o), 5);
    step();
    check("t3_result_sel", int'({state_o, SEL_o}), 17);
    check("t3_e4_total", dut_e4_pulses, 1);
    clear_flags();

    // T4 timeout alone, then tie
    goto_user();
    end_time_i = 1; step();
    check("t4_timeout", int'(state_o), 8);
    goto_user();
    end_time_i = 1; end_User_i = 1; match_i = 1; step();
    check("t4_tie", int'(state_o), 5);

    // T5 game won, result display and restart
    step(); step();
    clear_flags(); win_i = 1; step();
    check("t5_result", int'(state_o), 8);
    win_i = 0;
`ifdef GENIUS_RESULT_HOLD_EN
    repeat (Hold - 1) step();
    check("t5_hold_still", int'(state_o), 8);
    step();
    check("t5_hold_exit", int'(state_o), 0);
`else
    repeat (1000) step();
    check("t5_hold_1000", int'(state_o), 8);
    enter_i = 1; step();
    check("t5_enter_exit", int'(state_o), 0);
    enter_i = 0;
`endif

    // T6 abort from user entry, ENTER held across reset
    goto_user();
    R_i = 1; step();
    check("t6_abort", int'(state_o), 0);
    enter_i = 1; step();
    R_i = 0; step();
    step(); step();
    check("t6_held_no_fire", int'(state_o), 1);
    enter_i = 0; step();
    enter_i = 1; step();
    check("t6_refire", int'(state_o), 2);
    enter_i = 0;

    // Random play
    for (int i = 0; i < 4000; i++) begin
      R_i        = ($urandom_range(0, 199) == 0);
      enter_i    = ($urandom_range(0, 3) == 0);
      end_FPGA_i = ($urandom_range(0, 2) == 0);
      end_User_i = ($urandom_range(0, 3) == 0);
      end_time_i = ($urandom_range(0, 7) == 0);
      win_i      = ($urandom_range(0, 2) == 0);
      match_i    = ($urandom_range(0, 1) == 0);
      step();
    end
    R_i = 0; clear_flags(); enter_i = 0;
    step();
    check("e4_pulse_count", dut_e4_pulses, m_rounds_won);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
